// File: rtl/frame_mem_arbiter.sv
// Round-robin arbiter sharing one single-port frame SRAM between three pixel-pipeline requesters.
// Registers the winning SRAM command and tags each read return with the requester ID.
module frame_mem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  rvalid,
  output logic [1:0]            rid,
  output logic [DATA_W-1:0]     rdata
);

  logic [1:0] rr_ptr;
  logic [1:0] ptr_eff;
  logic [1:0] gnt_id;
  logic       any_gnt;
  logic [2:0] sum;
  logic [1:0] cand;
  logic [1:0] cmd_id;
  logic       rd_pend;
  logic [1:0] rd_id;

  // Search from rr_ptr upward modulo 3; an illegal pointer value of 3 behaves as 0.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    sum     = '0;
    cand    = '0;
    ptr_eff = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
    if (enb && !rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        sum  = {1'b0, ptr_eff} + 3'(i);
        cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        if (!any_gnt && req[cand]) begin
          any_gnt = 1'b1;
          gnt_id  = cand;
        end
      end
    end
    if (any_gnt) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      cmd_id     <= '0;
      rd_pend    <= 1'b0;
      rd_id      <= '0;
    end else begin
      if (any_gnt) begin
        rr_ptr     <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
        sram_en    <= 1'b1;
        sram_we    <= we[gnt_id];
        sram_addr  <= addr[int'(gnt_id)*ADDR_W +: ADDR_W];
        sram_wdata <= wdata[int'(gnt_id)*DATA_W +: DATA_W];
        cmd_id     <= gnt_id;
      end else begin
        sram_en <= 1'b0;
        sram_we <= 1'b0;
      end
      rd_pend <= sram_en & ~sram_we;
      rd_id   <= cmd_id;
    end
  end

  assign rvalid = rd_pend;
  assign rid    = rd_id;
  assign rdata  = sram_rdata;

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Round-robin arbiter that shares one single-port frame SRAM between three pixel-pipeline requesters: background read (sigma-delta input), background/variance write-back, and motion-map write. It sits between the pipeline stages and the SRAM macro. It grants at most one access per cycle, registers the SRAM command, and returns read data tagged with the requester ID. The frame control FSM gates it through `enb`.

## Interface
- ADDR_W, 17, SRAM word address width
- DATA_W, 8, SRAM data width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enb  in  1  arbitration enable from frame control; low = no new grants
- req  in  3  per-requester access request; bit i = requester i
- we  in  3  per-requester write flag; 1 = write, 0 = read
- addr  in  3*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  per-requester write data; same slicing
- gnt  out  3  one-hot grant, combinational, same cycle as request
- sram_en  out  1  registered SRAM chip enable
- sram_we  out  1  registered SRAM write enable
- sram_addr  out  ADDR_W  registered SRAM address
- sram_wdata  out  DATA_W  registered SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read command
- rvalid  out  1  read-return strobe
- rid  out  2  requester ID of the returned read (0..2)
- rdata  out  DATA_W  returned read data, passthrough of sram_rdata

## Operation
- Requesters:
  - Requester i holds req[i], we[i], addr slice and wdata slice stable until gnt[i] is high.
  - A granted requester drops req or presents its next access in the following cycle.
- Arbitration:
  - rr_ptr is a 2-bit register, values 0..2.
  - Search order: rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3. The first asserted req wins.
  - gnt = 0 when enb=0 or req=0.
  - After a grant to k, rr_ptr <= (k+1) mod 3. Without a grant, rr_ptr holds.
  - rr_ptr never takes value 3. If it ever does, treat it as 0.
- A lone requester with continuous req is granted every cycle; there is no idle bubble.
- Fairness: a requester holding req while enb=1 is granted within 3 cycles.
- Command register, updated every cycle:
  - With a grant to k: sram_en<=1, sram_we<=we[k], sram_addr<=addr slice k, sram_wdata<=wdata slice k.
  - Without a grant: sram_en<=0 and sram_we<=0. sram_addr and sram_wdata hold their values.
- Read tracking:
  - A 1-entry shadow holds rd_pend and rd_id.
  - rd_pend <= sram_en & ~sram_we. rd_id <= ID of the registered command.
  - rvalid = rd_pend, rid = rd_id, rdata = sram_rdata.
- Writes produce no return.
- Ordering is strict issue order, so a read after a write to the same address (granted later) returns the new data.

## Timing
- Reset values: gnt=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, rvalid=0, rid=0, rr_ptr=0.
- Read pipeline:
  - Cycle N: req[k] seen and gnt[k] high.
  - Cycle N+1: SRAM command visible on sram_*.
  - Cycle N+2: rvalid=1, rid=k, rdata valid.
  - Read latency is 2 cycles from grant. Throughput is 1 access per cycle.
- Writes reach the SRAM port at N+1.
- enb falling: no grant that cycle. Commands already registered complete, and their read returns still arrive.
- Simultaneous requests: exactly one grant, chosen by rr_ptr order. The others stay pending without loss.
- Reset asserted mid-operation:
  - All registers clear immediately.
  - An in-flight read return is dropped (rvalid=0).
  - rr_ptr returns to 0.

## Test plan
- Single read: enb=1, req=001, we=0, addr0=0x00010.
  - Cycle 0: gnt=001.
  - Cycle 1: sram_en=1, sram_we=0, sram_addr=0x00010.
  - Cycle 2 (sram_rdata=0x5A): rvalid=1, rid=0, rdata=0x5A.
- All three request continuously from reset:
  - Grants cycle 0..5 = 001, 010, 100, 001, 010, 100.
  - Read returns carry matching rid two cycles after each grant.
- Write then read, same address:
  - req1 writes 0x33 at 0x00100 while req0 reads 0x00100 (rr_ptr=1).
  - sram write issues at cycle 1, sram read at cycle 2, rvalid with rid=0 at cycle 3.
- enb=0 with req=111 for 4 cycles:
  - gnt=0 and sram_en=0 throughout, rr_ptr unchanged.
  - When enb rises, the first grant goes to the rr_ptr requester.
- Reset mid-read:
  - Read granted at cycle 0, rst pulsed in cycle 1.
  - rvalid stays 0 in cycle 2, and all outputs read their reset values.
- Lone streaming requester: req=100 for 10 cycles.
  - gnt[2]=1 every cycle, sram_en=1 from cycle 1 to 10, 10 rvalid pulses with rid=2.
